// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: write-side front end of the integer register file.
// Merges single-cycle ALU results and buffered load results into one
// registered write per cycle (we3_o/ad3_o/wd3_o). The ALU always has
// priority. Load results wait in a small FIFO. A starvation counter raises
// stall_o so that the FIFO head eventually gets a write slot.
// pending_o marks registers that have a load write still in flight.
//
// Optional feature macro: WB_LOAD_BYPASS_EN. When it is defined, a load that
// arrives with the FIFO empty and no ALU write skips the FIFO and is written
// one cycle later.
//
// Load handshake: a load transfers on a rising edge where ld_valid_i and
// ld_ready_o are both high. ld_ready_o depends only on the registered count,
// and on rst_i. The ALU port has no ready signal: a valid ALU result is
// always taken.
module reg_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]      alu_rd_i,
    input  logic [DATA_WIDTH-1:0]      alu_data_i,
    input  logic                       ld_valid_i,
    output logic                       ld_ready_o,
    input  logic [ADDR_WIDTH-1:0]      ld_rd_i,
    input  logic [DATA_WIDTH-1:0]      ld_data_i,
    output logic                       we3_o,
    output logic [ADDR_WIDTH-1:0]      ad3_o,
    output logic [DATA_WIDTH-1:0]      wd3_o,
    output logic                       stall_o,
    output logic [(2**ADDR_WIDTH)-1:0] pending_o
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int NREG = 2 ** ADDR_WIDTH;

    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    // FIFO storage and bookkeeping
    logic [ADDR_WIDTH-1:0] mem_rd_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    // Output stage; out_ld_q is high when the stage holds a load write
    logic                  we3_q, we3_d;
    logic [ADDR_WIDTH-1:0] ad3_q, ad3_d;
    logic [DATA_WIDTH-1:0] wd3_q, wd3_d;
    logic                  out_ld_q, out_ld_d;

    // Starvation tracking
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;

    // Per-cycle decisions
    logic alu_sel;
    logic fifo_empty;
    logic ld_ready;
    logic ld_hs;
    logic ld_keep;
    logic byp;
    logic pop;
    logic push;

    logic [FIFO_DEPTH-1:0] entry_valid;
    logic [NREG-1:0]       pending_c;

    assign fifo_empty = (count_q == '0);
    assign ld_ready   = !rst_i && (count_q < DEPTH_C);
    assign alu_sel    = alu_valid_i && (alu_rd_i != '0);
    assign ld_hs      = ld_valid_i && ld_ready;
    // A load to x0 finishes its handshake but is not stored
    assign ld_keep    = ld_hs && (ld_rd_i != '0);
    // The FIFO head gets the slot whenever the ALU does not take it
    assign pop        = !alu_sel && !fifo_empty;

`ifdef WB_LOAD_BYPASS_EN
    assign byp = ld_keep && fifo_empty && !alu_sel;
`else
    assign byp = 1'b0;
`endif

    assign push = ld_keep && !byp;

    // Next-state for output stage, FIFO pointers and starvation counter
    always_comb begin
        we3_d    = 1'b0;
        ad3_d    = ad3_q;
        wd3_d    = wd3_q;
        out_ld_d = 1'b0;
        if (alu_sel) begin
            we3_d = 1'b1;
            ad3_d = alu_rd_i;
            wd3_d = alu_data_i;
        end else if (pop) begin
            we3_d    = 1'b1;
            ad3_d    = mem_rd_q[rd_ptr_q];
            wd3_d    = mem_data_q[rd_ptr_q];
            out_ld_d = 1'b1;
        end else if (byp) begin
            we3_d    = 1'b1;
            ad3_d    = ld_rd_i;
            wd3_d    = ld_data_i;
            out_ld_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Count the cycles the waiting head loses to the ALU. The count
        // saturates at the limit and clears on a pop or when the FIFO is empty.
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_sel && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == LIMIT_C);
    end

    // Registered state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
            out_ld_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
            out_ld_q <= out_ld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // FIFO payload storage; the pointers and count decide which entries are valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= ld_rd_i;
            mem_data_q[wr_ptr_q] <= ld_data_i;
        end
    end

    // An entry is valid when its distance from the read pointer is below count
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_valid
        assign entry_valid[g] = ({1'b0, PW'(g) - rd_ptr_q} < count_q);
    end

    // Pending map: destinations of queued loads plus a load in the output stage
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_c[mem_rd_q[i]] = 1'b1;
            end
        end
        if (out_ld_q) begin
            pending_c[ad3_q] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    assign ld_ready_o = ld_ready;
    assign we3_o      = we3_q;
    assign ad3_o      = ad3_q;
    assign wd3_o      = wd3_q;
    assign stall_o    = stall_q;
    assign pending_o  = pending_c;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter. The reference model keeps the queued loads
// as a queue of {rd, data}. It applies the write-selection rules one cycle
// at a time. WB_LOAD_BYPASS_EN selects the bypass variant of the model.
module tb_reg_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;
    localparam int NREG  = 2 ** AW;
`ifdef WB_LOAD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Clock / reset / DUT signals
    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            alu_valid_i = 1'b0;
    logic [AW-1:0]   alu_rd_i = '0;
    logic [DW-1:0]   alu_data_i = '0;
    logic            ld_valid_i = 1'b0;
    logic            ld_ready_o;
    logic [AW-1:0]   ld_rd_i = '0;
    logic [DW-1:0]   ld_data_i = '0;
    logic            we3_o;
    logic [AW-1:0]   ad3_o;
    logic [DW-1:0]   wd3_o;
    logic            stall_o;
    logic [NREG-1:0] pending_o;

    always #5 clk_i = ~clk_i;

    reg_wb_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .alu_valid_i(alu_valid_i),
        .alu_rd_i   (alu_rd_i),
        .alu_data_i (alu_data_i),
        .ld_valid_i (ld_valid_i),
        .ld_ready_o (ld_ready_o),
        .ld_rd_i    (ld_rd_i),
        .ld_data_i  (ld_data_i),
        .we3_o      (we3_o),
        .ad3_o      (ad3_o),
        .wd3_o      (wd3_o),
        .stall_o    (stall_o),
        .pending_o  (pending_o)
    );

    // Reference model state
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ld_t;

    ld_t           exp_q[$];
    logic          m_we     = 1'b0;
    logic [AW-1:0] m_ad     = '0;
    logic [DW-1:0] m_wd     = '0;
    logic          m_out_ld = 1'b0;
    int            m_starve = 0;
    logic          m_stall  = 1'b0;

    int checks = 0;
    int errors = 0;

    function automatic logic [NREG-1:0] exp_pending();
        logic [NREG-1:0] p;
        p = '0;
        foreach (exp_q[k]) p[exp_q[k].rd] = 1'b1;
        if (m_out_ld) p[m_ad] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One clock cycle: drive, check ready, clock, advance model, check outputs
    task automatic step(input bit r, input bit av, input logic [AW-1:0] ar,
                        input logic [DW-1:0] adat, input bit lv,
                        input logic [AW-1:0] lr, input logic [DW-1:0] ldat);
        bit   ready;
        bit   hs;
        bit   alu_w;
        bit   bypassed;
        bit   popped;
        int   size_pre;
        ld_t  e;
        rst_i       = r;
        alu_valid_i = av;
        alu_rd_i    = ar;
        alu_data_i  = adat;
        ld_valid_i  = lv;
        ld_rd_i     = lr;
        ld_data_i   = ldat;
        ready = !r && (exp_q.size() < DEPTH);
        #1;
        checks++;
        if (ld_ready_o !== ready) begin
            errors++;
            $display("FAIL ld_ready t=%0t got %b expected %b", $time, ld_ready_o, ready);
        end
        @(posedge clk_i);
        if (r) begin
            exp_q.delete();
            m_we = 0; m_ad = '0; m_wd = '0; m_out_ld = 0; m_starve = 0; m_stall = 0;
        end else begin
            hs       = lv && ready;
            alu_w    = av && (ar != '0);
            size_pre = exp_q.size();
            bypassed = 0;
            popped   = 0;
            if (alu_w) begin
                m_we = 1; m_ad = ar; m_wd = adat; m_out_ld = 0;
            end else if (size_pre > 0) begin
                e = exp_q.pop_front();
                m_we = 1; m_ad = e.rd; m_wd = e.data; m_out_ld = 1;
                popped = 1;
            end else if (BYPASS && hs && lr != '0) begin
                m_we = 1; m_ad = lr; m_wd = ldat; m_out_ld = 1;
                bypassed = 1;
            end else begin
                m_we = 0; m_out_ld = 0;
            end
            if (hs && lr != '0 && !bypassed) exp_q.push_back('{rd: lr, data: ldat});
            if (popped || size_pre == 0) m_starve = 0;
            else if (alu_w && m_starve < LIMIT) m_starve++;
            m_stall = (m_starve == LIMIT);
        end
        #1;
        checks++;
        if (we3_o !== m_we) begin
            errors++;
            $display("FAIL we3 t=%0t got %b expected %b", $time, we3_o, m_we);
        end
        checks++;
        if (ad3_o !== m_ad) begin
            errors++;
            $display("FAIL ad3 t=%0t got %0d expected %0d", $time, ad3_o, m_ad);
        end
        checks++;
        if (wd3_o !== m_wd) begin
            errors++;
            $display("FAIL wd3 t=%0t got %h expected %h", $time, wd3_o, m_wd);
        end
        checks++;
        if (stall_o !== m_stall) begin
            errors++;
            $display("FAIL stall t=%0t got %b expected %b", $time, stall_o, m_stall);
        end
        checks++;
        if (pending_o !== exp_pending()) begin
            errors++;
            $display("FAIL pending t=%0t got %h expected %h", $time, pending_o, exp_pending());
        end
        if (we3_o === 1'b1) begin
            checks++;
            if (ad3_o === '0) begin
                errors++;
                $display("FAIL x0_write t=%0t got addr %0d expected nonzero", $time, ad3_o);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_reset();
        step(1, 0, '0, '0, 0, '0, '0);
        step(1, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
        idle(1);
    endtask

    task automatic test_alu_write();
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        idle(2);
    endtask

    task automatic test_load_latency();
        step(0, 0, '0, '0, 1, 5'd7, 32'h1234);
        checks++;
        if (pending_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL pending7_after_accept got %b expected 1", pending_o[7]);
        end
        idle(3);
        checks++;
        if (pending_o[7] !== 1'b0) begin
            errors++;
            $display("FAIL pending7_after_write got %b expected 0", pending_o[7]);
        end
    endtask

    task automatic test_fill_stall();
        for (int c = 0; c < 5; c++)
            step(0, !m_stall, 5'd9, $urandom, 1, AW'(c + 1), $urandom);
        for (int c = 0; c < 3; c++)
            step(0, !m_stall, 5'd9, $urandom, 0, '0, '0);
        idle(6);
    endtask

    task automatic test_alu_x0();
        step(0, 1, 5'd9, 32'h55, 1, 5'd3, 32'hCAFE0003);
        step(0, 1, 5'd0, 32'hBAD00000, 0, '0, '0);
        idle(2);
    endtask

    task automatic test_load_x0();
        step(0, 0, '0, '0, 1, 5'd0, 32'h0BAD0BAD);
        idle(2);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++)
            step(0, 1, 5'd20, $urandom, 1, AW'(10 + c), $urandom);
        step(1, 0, '0, '0, 0, '0, '0);
        idle(5);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) == 0),
                 !m_stall && ($urandom_range(0, 99) < 55),
                 AW'($urandom_range(0, NREG - 1)), $urandom,
                 ($urandom_range(0, 99) < 50),
                 AW'($urandom_range(0, NREG - 1)), $urandom);
        end
        idle(8);
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_latency();
        test_fill_stall();
        test_alu_x0();
        test_load_x0();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
